// File: rtl/div32_iter_pkg.sv
// Shared definitions for the iterative RV32M divider.
// Op encodings, FSM states and special-case result constants.
package div32_iter_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // DIV and REM treat operands as two's complement
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract.
// Purely combinational; the caller registers the outputs.
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem,
    input  logic         bit_in,
    input  logic [N-1:0] dvsr,
    output logic [N:0]   rem_next,
    output logic         q_bit
);

    logic [N:0] rem_sh;
    logic [N:0] trial;
    // The partial remainder stays below the divisor, so its top bit is
    // always clear before the shift and can be dropped.
    logic       unused_rem_msb;

    // Shift, trial-subtract and restore when the subtraction underflows
    always_comb begin
        unused_rem_msb = rem[N];
        rem_sh         = {rem[N-1:0], bit_in};
        trial          = rem_sh - {1'b0, dvsr};
        q_bit          = ~trial[N];
        rem_next       = q_bit ? trial : rem_sh;
    end

endmodule

// File: rtl/div32_iter.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with early exits for divide-by-zero and signed overflow.
module div32_iter
    import div32_iter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    state_e       state;
    logic [1:0]   op_q;
    logic         x_neg;
    logic         y_neg;
    logic [N-1:0] dvd;
    logic [N-1:0] ymag;
    logic [N:0]   rem;
    logic [4:0]   cnt;

    logic         x_neg_in;
    logic         y_neg_in;
    logic [N-1:0] xmag_in;
    logic [N-1:0] ymag_in;
    logic         div_zero;
    logic         ovf;
    logic [N-1:0] early_val;
    logic [N:0]   step_rem;
    logic         step_q;
    logic [N-1:0] q_fix;
    logic [N-1:0] r_fix;
    logic [N-1:0] fix_val;

    // Operand magnitudes and special-case detection at acceptance
    always_comb begin
        x_neg_in = is_signed_op(op) & X[N-1];
        y_neg_in = is_signed_op(op) & Y[N-1];
        xmag_in  = x_neg_in ? -X : X;
        ymag_in  = y_neg_in ? -Y : Y;
        div_zero = (Y == '0);
        ovf      = is_signed_op(op) && (X == INT_MIN)
                   && (Y == DIV_BY_ZERO_Q);
        if (div_zero)
            early_val = is_rem_op(op) ? X : DIV_BY_ZERO_Q;
        else
            early_val = is_rem_op(op) ? '0 : INT_MIN;
    end

    div_step #(.N(N)) u_step (
        .rem      (rem),
        .bit_in   (dvd[N-1]),
        .dvsr     (ymag),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Sign correction of the unsigned quotient/remainder
    always_comb begin
        q_fix   = (x_neg ^ y_neg) ? -dvd : dvd;
        r_fix   = x_neg ? -rem[N-1:0] : rem[N-1:0];
        fix_val = is_rem_op(op_q) ? r_fix : q_fix;
    end

    // Control FSM; dvd doubles as the quotient shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            x_neg  <= 1'b0;
            y_neg  <= 1'b0;
            dvd    <= '0;
            ymag   <= '0;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        x_neg <= x_neg_in;
                        y_neg <= y_neg_in;
                        dvd   <= xmag_in;
                        ymag  <= ymag_in;
                        rem   <= '0;
                        cnt   <= 5'd31;
                        if (div_zero || ovf) begin
                            result <= early_val;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem <= step_rem;
                    dvd <= {dvd[N-2:0], step_q};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_val;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
